animation_ladder_ctrl: RTL and testbench
========================================

# animation_ladder_ctrl

Sequencer that drives the ladder-overlay stage's `animation` enable and 4-bit `counter` step index. After a trigger during an active game, it advances `counter` by one step every `FRAMES_PER_STEP` video frames until it reaches `LAST_STEP`, then holds. Frame timing comes from rising edges of `vsync`, so `counter` changes only inside vertical blanking. It sits beside the timing generator and feeds the overlay stage directly.

## Interface
- `FRAMES_PER_STEP`, default 8: frames per counter step; legal range 1..256.
- `LAST_STEP`, default 15: final `counter` value; legal range 1..15.

- `clk` in 1: pixel clock, shared with the VGA pipeline.
- `rst` in 1: reset, asynchronous, active-low.
- `start_game` in 1: game active level; low forces the block idle.
- `trigger` in 1: request to start the animation; sampled only in IDLE.
- `vsync` in 1: VGA vsync from the timing generator; a rising edge is one frame tick.
- `animation` out 1: high while the ladder animation is running or held.
- `counter` out 4: current step index, 0..`LAST_STEP`.
- `busy` out 1: high in RUN only.
- `done` out 1: one-cycle pulse when `counter` reaches `LAST_STEP`.

## Operation
- Frame tick:
  - Register `vsync_q` (reset 0).
  - `tick = vsync & ~vsync_q`.
  - At most one tick per frame.
- Frame counter `frame_cnt`: width 8 bits, reset 0.
- FSM states: IDLE, RUN, HOLD. All outputs are registered.
- IDLE:
  - Outputs: `animation`=0, `counter`=0, `busy`=0, `done`=0.
  - `start_game && trigger` → RUN, with `frame_cnt`=0 and `counter`=0.
- RUN:
  - Outputs: `animation`=1, `busy`=1.
  - On a tick with `frame_cnt == FRAMES_PER_STEP-1`:
    - `frame_cnt` ← 0 and `counter` ← `counter`+1.
    - If the new value equals `LAST_STEP`, go to HOLD and set `done` ← 1 for exactly one cycle.
  - On any other tick: `frame_cnt` ← `frame_cnt`+1.
  - No tick: all state holds.
- HOLD:
  - Outputs: `animation`=1, `counter`=`LAST_STEP`, `busy`=0.
  - Ticks are ignored.
  - Exit only when `start_game` goes low.
- `start_game`=0 in any state → IDLE on the next edge. This overrides all other events:
  - `counter`=0, `animation`=0, `frame_cnt`=0.
  - `done` is not asserted, even if a step completion coincides.
- `trigger` is ignored in RUN and HOLD. Retriggering requires passing through IDLE.
- `trigger` is a level sampled in IDLE. If it is held high across the return to IDLE while `start_game`=1, the animation restarts immediately.
- Arithmetic:
  - `counter` never exceeds `LAST_STEP` and never wraps.
  - `frame_cnt` compares against `FRAMES_PER_STEP-1` truncated to 8 bits (`FRAMES_PER_STEP`=256 → compare to 255).
- Asynchronous reset mid-RUN: all outputs and state go to their IDLE/reset values immediately, with no `done` pulse.

## Timing
- Reset values: `animation`=0, `counter`=0, `busy`=0, `done`=0, state IDLE, `frame_cnt`=0, `vsync_q`=0.
- Start latency: `trigger`&`start_game` at edge t → `animation`=`busy`=1 after edge t, visible cycle t+1.
- Tick latency:
  - The `vsync` rise is sampled at edge t, so `tick` is high during cycle t.
  - The `counter` update is visible from cycle t+1.
- A tick in the same cycle as the IDLE→RUN transition is not counted.
- Total run length: `LAST_STEP`×`FRAMES_PER_STEP` ticks from entry to RUN until HOLD.
- `done` is high in the same cycle that `counter` first shows `LAST_STEP`. It is low one cycle later.
- Abort latency: `start_game` low sampled at edge t → IDLE values visible cycle t+1.

## Test plan
All scenarios use `FRAMES_PER_STEP`=2, `LAST_STEP`=3 unless noted.

- Reset check: assert `rst`=0 mid-clock → all outputs 0 immediately. Release, hold `trigger`=0 → outputs stay 0 across 10 vsync pulses.
- Nominal run: `start_game`=1, pulse `trigger`, apply 6 vsync rises →
  - `counter` sequence 0,0,1,1,2,2,3, changing one cycle after the 2nd, 4th and 6th rise.
  - `done` is a single-cycle pulse with `counter`=3.
  - `busy` falls with `done`; `animation` stays 1.
- Hold and exit: after the nominal run, apply 5 more vsync rises → `counter` stays 3. Drop `start_game` → `counter`=0 and `animation`=0 next cycle.
- Abort mid-run: drop `start_game` at the cycle of the 4th tick → `counter`=0, no `done` pulse, state IDLE.
- Ignored trigger and coincident tick:
  - Pulse `trigger` in RUN → no restart, `counter` unaffected.
  - Start with a vsync rise in the trigger cycle → first step still needs 2 further ticks.
- `vsync` held high for 1000 cycles → exactly one tick counted. Repeat with `FRAMES_PER_STEP`=1, `LAST_STEP`=1 → `done` one cycle after the first tick.

Source files
------------

// File: rtl/animation_ladder_ctrl.sv
// Ladder-overlay animation sequencer: steps `counter` once every FRAMES_PER_STEP
// vsync frames after a trigger, then holds at LAST_STEP until the game ends.
//
//   state | meaning
//   IDLE  | no animation, counter 0, waiting for start_game && trigger
//   RUN   | counting vsync ticks, stepping counter toward LAST_STEP
//   HOLD  | counter parked at LAST_STEP, waiting for start_game to drop
module animation_ladder_ctrl #(
    parameter int FRAMES_PER_STEP = 8,
    parameter int LAST_STEP       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_game,
    input  logic       trigger,
    input  logic       vsync,
    output logic       animation,
    output logic [3:0] counter,
    output logic       busy,
    output logic       done
);

    // FRAMES_PER_STEP = 256 wraps to a compare against 255
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [3:0] STEP_LAST  = 4'(LAST_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       vsync_q;
    logic       tick;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] counter_q, counter_d;
    logic       animation_q, animation_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    assign tick = vsync & ~vsync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            counter_q   <= 4'd0;
            animation_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync;
            frame_cnt_q <= frame_cnt_d;
            counter_q   <= counter_d;
            animation_q <= animation_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        counter_d   = counter_q;
        animation_d = animation_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (!start_game) begin
            // game over wins over any step completion in the same cycle
            state_d     = IDLE;
            frame_cnt_d = 8'd0;
            counter_d   = 4'd0;
            animation_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    frame_cnt_d = 8'd0;
                    counter_d   = 4'd0;
                    animation_d = 1'b0;
                    busy_d      = 1'b0;
                    if (trigger) begin
                        state_d     = RUN;
                        animation_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                RUN: begin
                    animation_d = 1'b1;
                    busy_d      = 1'b1;
                    if (tick) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            frame_cnt_d = 8'd0;
                            counter_d   = counter_q + 4'd1;
                            if (counter_q + 4'd1 == STEP_LAST) begin
                                state_d = HOLD;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    animation_d = 1'b1;
                    busy_d      = 1'b0;
                    counter_d   = STEP_LAST;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign animation = animation_q;
    assign counter   = counter_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_animation_ladder_ctrl.sv
// Bench for animation_ladder_ctrl: vector tables replayed through a scoreboard
// queue, plus hand sequences for async reset and a long-held vsync.
module tb_animation_ladder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_game = 1'b0;
    logic       trigger = 1'b0;
    logic       vsync = 1'b0;
    logic       animation, busy, done;
    logic [3:0] counter;
    logic       animation1, busy1, done1;
    logic [3:0] counter1;

    animation_ladder_ctrl #(.FRAMES_PER_STEP(2), .LAST_STEP(3)) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .trigger(trigger),
        .vsync(vsync), .animation(animation), .counter(counter),
        .busy(busy), .done(done)
    );

    animation_ladder_ctrl #(.FRAMES_PER_STEP(1), .LAST_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start_game(start_game), .trigger(trigger),
        .vsync(vsync), .animation(animation1), .counter(counter1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sg;
        logic       trg;
        logic       vs;
        logic       anim;
        logic [3:0] cnt;
        logic       bsy;
        logic       dn;
    } vec_t;

    typedef struct {
        logic       anim;
        logic [3:0] cnt;
        logic       bsy;
        logic       dn;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic sg, input logic trg, input logic vs);
        start_game = sg;
        trigger    = trg;
        vsync      = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic sg, input logic trg, input logic vs,
                       input logic anim, input logic [3:0] cnt,
                       input logic bsy, input logic dn);
        vec_t v;
        v.sg = sg; v.trg = trg; v.vs = vs;
        v.anim = anim; v.cnt = cnt; v.bsy = bsy; v.dn = dn;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string tag);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            e.anim = tbl[i].anim; e.cnt = tbl[i].cnt;
            e.bsy  = tbl[i].bsy;  e.dn  = tbl[i].dn;
            sb.push_back(e);
            step(tbl[i].sg, tbl[i].trg, tbl[i].vs);
            e = sb.pop_front();
            chk($sformatf("%s[%0d].animation", tag, i), {3'b0, animation}, {3'b0, e.anim});
            chk($sformatf("%s[%0d].counter", tag, i), counter, e.cnt);
            chk($sformatf("%s[%0d].busy", tag, i), {3'b0, busy}, {3'b0, e.bsy});
            chk($sformatf("%s[%0d].done", tag, i), {3'b0, done}, {3'b0, e.dn});
        end
        tbl.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".animation"}, {3'b0, animation}, 4'd0);
        chk({tag, ".counter"}, counter, 4'd0);
        chk({tag, ".busy"}, {3'b0, busy}, 4'd0);
        chk({tag, ".done"}, {3'b0, done}, 4'd0);
    endtask

    int changes;
    int done1_hits;

    initial begin
        #1 rst = 1'b0;
        #1 chk_zero("reset");
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // trigger low: ten frames pass with nothing happening
        for (int i = 0; i < 10; i++) begin
            add(1, 0, 1, 0, 0, 0, 0);
            add(1, 0, 0, 0, 0, 0, 0);
        end
        run_tbl("idle");

        // nominal run, hold, exit
        add(1, 1, 0, 1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 2, 1, 0);
        add(1, 0, 0, 1, 2, 1, 0);
        add(1, 0, 1, 1, 2, 1, 0);
        add(1, 0, 0, 1, 2, 1, 0);
        add(1, 0, 1, 1, 3, 0, 1);
        add(1, 0, 0, 1, 3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            add(1, i[0], 1, 1, 3, 0, 0);
            add(1, 0, 0, 1, 3, 0, 0);
        end
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        run_tbl("nominal");

        // trigger held through RUN does not restart the count
        add(1, 1, 0, 1, 0, 1, 0);
        add(1, 1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 0);
        add(1, 1, 1, 1, 1, 1, 0);
        add(1, 1, 0, 1, 1, 1, 0);
        add(1, 1, 1, 1, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        run_tbl("trg_in_run");

        // tick in the trigger cycle is not counted; abort on the 4th tick
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        run_tbl("coincident_abort");

        // abort coinciding with the final step: no done pulse
        add(1, 1, 0, 1, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            add(1, 0, 1, 1, 4'(i / 2), 1, 0);
            add(1, 0, 0, 1, 4'(i / 2), 1, 0);
        end
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        run_tbl("abort_done");

        // asynchronous reset in the middle of RUN
        step(1, 1, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        chk("pre_reset.counter", counter, 4'd1);
        #2 rst = 1'b0;
        #1 chk_zero("async_reset");
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 1);
        chk_zero("after_reset");

        // vsync held high: one tick only; FPS=1/LAST=1 instance finishes on it
        step(0, 0, 0);
        step(1, 1, 0);
        chk("hold_hi.start.busy", {3'b0, busy}, 4'd1);
        chk("hold_hi.start1.busy", {3'b0, busy1}, 4'd1);
        step(1, 0, 1);
        chk("hold_hi.first.counter", counter, 4'd0);
        chk("fast.done", {3'b0, done1}, 4'd1);
        chk("fast.counter", counter1, 4'd1);
        chk("fast.busy", {3'b0, busy1}, 4'd0);
        changes    = 0;
        done1_hits = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1, 0, 1);
            if (counter !== 4'd0) changes++;
            if (done1 !== 1'b0) done1_hits++;
        end
        chk("hold_hi.counter_changes", 4'(changes), 4'd0);
        chk("fast.done_pulses_after", 4'(done1_hits), 4'd0);
        chk("fast.hold.animation", {3'b0, animation1}, 4'd1);
        chk("fast.hold.counter", counter1, 4'd1);
        step(1, 0, 0);
        chk("hold_hi.low.counter", counter, 4'd0);
        step(1, 0, 1);
        chk("hold_hi.second.counter", counter, 4'd1);
        chk("hold_hi.second.busy", {3'b0, busy}, 4'd1);
        step(0, 0, 0);
        chk_zero("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
